// File: rtl/half_precision_mul_sched_if.sv
// Request/response bundle for the shared binary16 multiplier scheduler.
// master = client side, slave = scheduler side.
interface half_precision_mul_sched_if #(
  parameter int NREQ = 4,
  parameter int N    = 16,
  parameter int IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [N-1:0]      rsp_p;
  logic [5:0]        rsp_flags;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_p, rsp_flags
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_p, rsp_flags
  );
endinterface

// File: rtl/half_precision_mul_sched.sv
// Round-robin scheduler sharing one combinational binary16 multiplier;
// S1 issues registered operands, S2 holds the tagged result.
module half_precision_mul_sched #(
  parameter int NREQ = 4,
  parameter int N    = 16,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic     clk,
  input  logic     rst,
  half_precision_mul_sched_if.slave bus,
  output logic [N-1:0] o_mul_a,
  output logic [N-1:0] o_mul_b,
  input  logic [N-1:0] i_mul_p,
  input  logic [5:0]   i_mul_flags,
  output logic         o_busy
);

  logic           r_s1_v;
  logic [IDW-1:0] r_s1_id;
  logic [N-1:0]   r_a;
  logic [N-1:0]   r_b;
  logic           r_s2_v;
  logic [IDW-1:0] r_s2_id;
  logic [N-1:0]   r_p;
  logic [5:0]     r_flags;
  logic [IDW-1:0] r_ptr;

  logic           w_s1_adv;
  logic           w_s2_adv;
  logic           w_any;
  logic           w_acc;
  logic [IDW-1:0] w_gid;
  logic [IDW-1:0] w_idx;
  logic [N-1:0]   w_a;
  logic [N-1:0]   w_b;

  function automatic logic [IDW-1:0] wrap(
    input logic [IDW-1:0] p,
    input int             k
  );
    int s;
    s = int'(p) + k;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  assign w_s2_adv = !r_s2_v | bus.rsp_ready;
  assign w_s1_adv = !r_s1_v | w_s2_adv;

  // Scan from far to near so the bit closest to r_ptr wins.
  always_comb begin
    w_any = 1'b0;
    w_gid = '0;
    w_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = wrap(r_ptr, k);
      if (bus.req_valid[w_idx]) begin
        w_any = 1'b1;
        w_gid = w_idx;
      end
    end
  end

  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gid == IDW'(i)) begin
        w_a = bus.req_a[i*N +: N];
        w_b = bus.req_b[i*N +: N];
      end
    end
  end

  assign w_acc = w_any & w_s1_adv & !rst;

  assign bus.req_ready =
    w_acc ? (NREQ'(1) << w_gid) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_v  <= 1'b0;
      r_s1_id <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_ptr   <= '0;
    end else if (w_s1_adv) begin
      r_s1_v <= w_acc;
      if (w_acc) begin
        r_s1_id <= w_gid;
        r_a     <= w_a;
        r_b     <= w_b;
        r_ptr   <= wrap(w_gid, 1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_v  <= 1'b0;
      r_s2_id <= '0;
      r_p     <= '0;
      r_flags <= '0;
    end else if (w_s2_adv) begin
      r_s2_v  <= r_s1_v;
      r_s2_id <= r_s1_id;
      r_p     <= i_mul_p;
      r_flags <= i_mul_flags;
    end
  end

  assign o_mul_a       = r_a;
  assign o_mul_b       = r_b;
  assign bus.rsp_valid = r_s2_v;
  assign bus.rsp_id    = r_s2_id;
  assign bus.rsp_p     = r_p;
  assign bus.rsp_flags = r_flags;
  assign o_busy        = r_s1_v | r_s2_v;

endmodule

// File: tb/tb_half_precision_mul_sched.sv
// Bench for half_precision_mul_sched: directed vector table, corner
// sequences, and a randomized run against a queue-based scoreboard.
module tb_half_precision_mul_sched;

  logic        clk;
  logic        rst;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic [15:0] mul_p;
  logic [5:0]  mul_flags;
  logic        busy;

  int n_chk;
  int n_fail;

  half_precision_mul_sched_if #(.NREQ(4), .N(16)) bus ();

  half_precision_mul_sched #(.NREQ(4), .N(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_mul_a     (mul_a),
    .o_mul_b     (mul_b),
    .i_mul_p     (mul_p),
    .i_mul_flags (mul_flags),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] cls(input logic [15:0] p);
    if (p[14:10] == 5'h1F) begin
      if (p[9:0] == 10'h0) return 6'b001000;
      return p[9] ? 6'b010000 : 6'b100000;
    end
    if (p[14:10] == 5'h00)
      return (p[9:0] == 10'h0) ? 6'b000100 : 6'b000010;
    return 6'b000001;
  endfunction

  // Simple truncating binary16 multiplier (subnormals flushed),
  // standing in for the external FPU datapath.
  function automatic logic [21:0] fmul(
    input logic [15:0] a,
    input logic [15:0] b
  );
    logic        s;
    logic [4:0]  ea;
    logic [4:0]  eb;
    logic [9:0]  fa;
    logic [9:0]  fb;
    logic [21:0] m;
    logic [9:0]  f;
    logic [15:0] p;
    int          e;
    s  = a[15] ^ b[15];
    ea = a[14:10];
    eb = b[14:10];
    fa = a[9:0];
    fb = b[9:0];
    if (ea == 5'h1F && fa != 0) p = a;
    else if (eb == 5'h1F && fb != 0) p = b;
    else if ((ea == 5'h1F && eb == 0) || (eb == 5'h1F && ea == 0))
      p = 16'h7E00;
    else if (ea == 5'h1F || eb == 5'h1F) p = {s, 15'h7C00};
    else if (ea == 0 || eb == 0) p = {s, 15'h0};
    else begin
      m = 22'({1'b1, fa}) * 22'({1'b1, fb});
      e = int'(ea) + int'(eb) - 15;
      if (m[21]) begin
        e = e + 1;
        f = m[20:11];
      end else begin
        f = m[19:10];
      end
      if (e >= 31) p = {s, 15'h7C00};
      else if (e <= 0) p = {s, 15'h0};
      else p = {s, e[4:0], f};
    end
    return {cls(p), p};
  endfunction

  always_comb {mul_flags, mul_p} = fmul(mul_a, mul_b);

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_op(
    input int          i,
    input logic [15:0] a,
    input logic [15:0] b
  );
    bus.req_a[i*16 +: 16] = a;
    bus.req_b[i*16 +: 16] = b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [15:0] rnd_half();
    case ($urandom_range(7))
      0: return 16'h7C00 | 16'($urandom_range(1) << 15);
      1: return 16'h7D00;
      2: return 16'h7E00;
      3: return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  typedef struct {
    int          id;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] p;
    logic [5:0]  f;
  } vec_t;

  typedef struct {
    int          id;
    logic [15:0] a;
    logic [15:0] b;
  } sb_t;

  vec_t        vt[7];
  sb_t         q[$];
  sb_t         e;
  logic [3:0]  pend;
  logic [3:0]  exp_g;
  logic [15:0] pa[4];
  logic [15:0] pb[4];
  logic [21:0] r;
  int          mptr;
  int          g;
  int          acc;
  int          nrsp;
  logic        can;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;

    vt[0] = '{2, 16'h3C00, 16'h4000, 16'h4000, 6'b000001};
    vt[1] = '{1, 16'h7D00, 16'h3C00, 16'h7D00, 6'b100000};
    vt[2] = '{0, 16'h7C00, 16'h0000, 16'h7E00, 6'b010000};
    vt[3] = '{3, 16'h3E00, 16'h3E00, 16'h4080, 6'b000001};
    vt[4] = '{1, 16'h7C00, 16'hC000, 16'hFC00, 6'b001000};
    vt[5] = '{2, 16'h0000, 16'h3C00, 16'h0000, 6'b000100};
    vt[6] = '{0, 16'h7E00, 16'h3C00, 16'h7E00, 6'b010000};

    // reset state, with all requesters asserting
    @(negedge clk);
    bus.req_valid = 4'hF;
    bus.rsp_ready = 1'b1;
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mul_a", 32'(mul_a), 0);
    chk("rst_mul_b", 32'(mul_b), 0);
    chk("rst_rsp_p", 32'(bus.rsp_p), 0);

    do_reset();
    for (int t = 0; t < 7; t++) begin
      set_op(vt[t].id, vt[t].a, vt[t].b);
      bus.req_valid = 4'(1 << vt[t].id);
      bus.rsp_ready = 1'b1;
      #1;
      chk("tbl_grant", 32'(bus.req_ready), 32'(1 << vt[t].id));
      @(negedge clk);
      bus.req_valid = '0;
      #1;
      chk("tbl_s1_rspv", 32'(bus.rsp_valid), 0);
      chk("tbl_mul_a", 32'(mul_a), 32'(vt[t].a));
      chk("tbl_busy", 32'(busy), 1);
      @(negedge clk);
      #1;
      chk("tbl_rspv", 32'(bus.rsp_valid), 1);
      chk("tbl_id", 32'(bus.rsp_id), 32'(vt[t].id));
      chk("tbl_p", 32'(bus.rsp_p), 32'(vt[t].p));
      chk("tbl_flags", 32'(bus.rsp_flags), 32'(vt[t].f));
      @(negedge clk);
    end
    #1 chk("tbl_idle", 32'(busy), 0);

    // round robin with all requesters held high
    do_reset();
    for (int i = 0; i < 4; i++)
      set_op(i, 16'h3C00, 16'h4000 + 16'(i << 10));
    bus.req_valid = 4'hF;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk("rr_grant", 32'(bus.req_ready), 32'(1 << (c % 4)));
      if (c >= 2) begin
        chk("rr_rspv", 32'(bus.rsp_valid), 1);
        chk("rr_id", 32'(bus.rsp_id), 32'((c - 2) % 4));
        chk("rr_p", 32'(bus.rsp_p),
            32'(16'h4000 + 16'(((c - 2) % 4) << 10)));
      end else begin
        chk("rr_rspv_fill", 32'(bus.rsp_valid), 0);
      end
      @(negedge clk);
    end
    bus.req_valid = '0;
    @(negedge clk);
    @(negedge clk);

    // backpressure: two accepts fill both stages, third waits
    do_reset();
    set_op(0, 16'h3E00, 16'h3E00);
    set_op(1, 16'h3E00, 16'h3E00);
    set_op(2, 16'h3C00, 16'h3C00);
    bus.req_valid = 4'b0111;
    bus.rsp_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (bus.req_ready != 0) acc++;
      exp_g = bus.req_ready;
      @(negedge clk);
      bus.req_valid = bus.req_valid & ~exp_g;
    end
    chk("bp_accepts", 32'(acc), 2);
    #1;
    chk("bp_valid_hold", 32'(bus.req_valid), 32'(4'b0100));
    chk("bp_full_ready", 32'(bus.req_ready), 0);
    chk("bp_rspv", 32'(bus.rsp_valid), 1);
    chk("bp_busy", 32'(busy), 1);
    chk("bp_hold_id", 32'(bus.rsp_id), 0);
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    nrsp = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      exp_g = bus.req_ready;
      if (bus.rsp_valid) begin
        chk("bp_id", 32'(bus.rsp_id), 32'(nrsp));
        chk("bp_p", 32'(bus.rsp_p),
            (nrsp < 2) ? 32'h4080 : 32'h3C00);
        nrsp++;
      end
      @(negedge clk);
      bus.req_valid = bus.req_valid & ~exp_g;
    end
    chk("bp_nrsp", 32'(nrsp), 3);

    // pointer wrap 3 -> 0
    do_reset();
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b1000;
    #1 chk("wrap_g3", 32'(bus.req_ready), 32'(4'b1000));
    @(negedge clk);
    bus.req_valid = 4'b0111;
    #1 chk("wrap_g0", 32'(bus.req_ready), 32'(4'b0001));
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);

    // reset with both stages occupied
    do_reset();
    set_op(0, 16'h3C00, 16'h4000);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0110;
    for (int c = 0; c < 2; c++) begin
      #1;
      exp_g = bus.req_ready;
      @(negedge clk);
      bus.req_valid = bus.req_valid & ~exp_g;
    end
    #1;
    chk("mf_busy_pre", 32'(busy), 1);
    chk("mf_rspv_pre", 32'(bus.rsp_valid), 1);
    bus.req_valid = 4'hF;
    rst = 1'b1;
    #1;
    chk("mf_rspv", 32'(bus.rsp_valid), 0);
    chk("mf_busy", 32'(busy), 0);
    chk("mf_ready", 32'(bus.req_ready), 0);
    chk("mf_mul_a", 32'(mul_a), 0);
    @(negedge clk);
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    #1 chk("mf_first_grant", 32'(bus.req_ready), 32'(4'b0001));
    @(negedge clk);
    bus.req_valid = '0;
    nrsp = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (bus.rsp_valid) begin
        chk("mf_id", 32'(bus.rsp_id), 0);
        chk("mf_p", 32'(bus.rsp_p), 32'h4000);
        nrsp++;
      end
      @(negedge clk);
    end
    chk("mf_nrsp", 32'(nrsp), 1);

    // randomized traffic against the scoreboard
    do_reset();
    pend = '0;
    mptr = 0;
    q.delete();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(2) == 0) begin
          pend[i] = 1'b1;
          pa[i] = rnd_half();
          pb[i] = rnd_half();
          set_op(i, pa[i], pb[i]);
        end
      end
      bus.req_valid = pend;
      if (((c / 200) % 2) == 1)
        bus.rsp_ready = ($urandom_range(3) == 0);
      else
        bus.rsp_ready = ($urandom_range(3) != 0);
      #1;
      exp_g = '0;
      g = 0;
      can = (q.size() < 2) || bus.rsp_ready;
      if (can && pend != 0) begin
        for (int k = 3; k >= 0; k--)
          if (pend[(mptr + k) % 4]) g = (mptr + k) % 4;
        exp_g = 4'(1 << g);
      end
      chk("rnd_grant", 32'(bus.req_ready), 32'(exp_g));
      chk("rnd_busy", 32'(busy), 32'(q.size() != 0));
      if (q.size() == 0)
        chk("rnd_rspv_idle", 32'(bus.rsp_valid), 0);
      if (bus.rsp_valid && bus.rsp_ready && q.size() != 0) begin
        e = q.pop_front();
        r = fmul(e.a, e.b);
        chk("rnd_id", 32'(bus.rsp_id), 32'(e.id));
        chk("rnd_p", 32'(bus.rsp_p), 32'(r[15:0]));
        chk("rnd_flags", 32'(bus.rsp_flags), 32'(r[21:16]));
      end
      if (exp_g != 0) begin
        q.push_back('{g, pa[g], pb[g]});
        pend[g] = 1'b0;
        mptr = (g + 1) % 4;
      end
      @(negedge clk);
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (bus.rsp_valid && q.size() != 0) begin
        e = q.pop_front();
        r = fmul(e.a, e.b);
        chk("drain_id", 32'(bus.rsp_id), 32'(e.id));
        chk("drain_p", 32'(bus.rsp_p), 32'(r[15:0]));
      end
      @(negedge clk);
    end
    chk("drain_empty", 32'(q.size()), 0);
    #1 chk("drain_busy", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/half_precision_mul_sched.md
# half_precision_mul_sched

Round-robin scheduler that shares one combinational half-precision (IEEE-754 binary16) multiplier among NREQ requesters. Each requester presents an operand pair with a valid/ready handshake; the block arbitrates, registers operands into the shared multiplier, captures the product and its six class flags, and returns them tagged with the requester id over a single valid/ready response port. It sits between the client pipelines and the FPU multiply datapath.

## Interface

- NREQ, 4 — number of requesters (≥2)
- N, 16 — operand/product width (binary16)
- IDW, $clog2(NREQ) — response id width
- clk  in  1 — clock, rising edge
- rst  in  1 — reset, asynchronous, active-high
- req_valid  in  NREQ — request valid, bit i = requester i
- req_ready  out  NREQ — one-hot grant/accept; bit i high = requester i's operands taken this edge
- req_a, req_b  in  NREQ*N — operand buses, requester i at [i*N +: N]
- mul_a, mul_b  out  N — operands to the shared multiplier (registered)
- mul_p  in  N — multiplier product (combinational from mul_a/mul_b)
- mul_flags  in  6 — multiplier class flags {snan,qnan,infinity,zero,subnormal,normal}
- rsp_valid  out  1 — response valid
- rsp_ready  in  1 — response consumer ready
- rsp_id  out  IDW — requester index of the response
- rsp_p  out  N — product
- rsp_flags  out  6 — flags, same order as mul_flags
- busy  out  1 — high when either pipeline stage holds an operation

## Operation

- Two register stages: S1 (issue: s1_valid, operands, id) drives mul_a/mul_b; S2 (result: s2_valid, mul_p, mul_flags, id) drives rsp_*.
- Stall rules: s2_adv = !s2_valid | rsp_ready; s1_adv = !s1_valid | s2_adv.
- S2 loads S1's content (s2_valid ← s1_valid) when s2_adv; otherwise holds.
- Arbiter: round-robin over req_valid starting at pointer ptr; grant = first set bit at or after ptr, wrapping NREQ-1 → 0.
- req_ready = grant one-hot when s1_adv, else all zero. req_ready[i] never high while req_valid[i] low.
- On accept of requester g: S1 ← {1, req_a[g], req_b[g], g}; ptr ← g+1 mod NREQ. With no accept ptr holds.
- S1 with s1_adv and no request: s1_valid ← 0.
- Requesters hold req_valid and operands stable until accepted; the block does not depend on withdrawal behaviour.
- Block passes mul_p/mul_flags through unmodified; NaN/inf/zero handling is the multiplier's.
- busy = s1_valid | s2_valid.
- Reset (any time, including mid-operation): s1_valid, s2_valid ← 0; ptr ← 0; mul_a, mul_b, rsp_p ← 0; rsp_id ← 0; rsp_flags ← 0. In-flight operations are discarded; no response is produced for them.
- Reset output values: req_ready = 0 while rst high, rsp_valid = 0, busy = 0, mul_a = mul_b = 0.

## Timing

- Accept at edge k → mul_a/mul_b valid during cycle k..k+1 → product captured at edge k+1 → rsp_valid high after edge k+1. Latency: 2 edges from accept to response capture.
- Throughput: one operation per cycle with rsp_ready held high.
- rsp_valid high with rsp_ready low: rsp_* stable until handshake edge.
- Full backpressure (both stages valid, rsp_ready low): req_ready = 0.
- S2 full, S1 empty, rsp_ready low: S1 still accepts one request (one-slot skid).
- Simultaneous requests: exactly one grant per cycle; a continuously asserting requester waits at most NREQ-1 grants.
- req_ready is combinational from req_valid, ptr, s1_valid, s2_valid, rsp_ready; no combinational path from req_a/req_b or mul_p to any output.

## Test plan

- Single op: requester 2 sends a=0x3C00 (1.0), b=0x4000 (2.0), rsp_ready=1 → rsp_valid 2 edges after accept, rsp_id=2, rsp_p=0x4000, rsp_flags=6'b000001.
- Round robin: all four req_valid held high from reset, rsp_ready=1 → grant order 0,1,2,3,0,1; responses in same order, one per cycle after 2-cycle fill.
- Backpressure: requesters 0 and 1 stream 0x3E00×0x3E00 (1.5²) with rsp_ready=0 → exactly two accepts, then req_ready=0; raise rsp_ready → rsp_p=0x4080 twice, ids 0,1, no loss or duplication.
- Exception pass-through: a=0x7D00 (sNaN), b=0x3C00 → rsp_p=0x7D00, rsp_flags=6'b100000; a=0x7C00, b=0x0000 → rsp_flags=6'b010000 (qNaN).
- Pointer wrap: only requester 3 then requester 0 valid → grants 3 then 0; after grant 3, ptr=0.
- Reset mid-flight: assert rst with S1 and S2 both valid → rsp_valid, busy, req_ready drop immediately; after release no stale responses, first grant goes to requester 0.
